// File: rtl/rob_commit_pkg.sv
// Shared ROB constants and entry layout.
// Alias table imports the same TAG_W.
package rob_commit_pkg;
   localparam int TAG_W  = 5;
   localparam int DEPTH  = 2**TAG_W;
   localparam int DATA_W = 32;
   localparam int REG_W  = 5;

   typedef struct packed {
      logic              valid;
      logic              done;
      logic              has_dest;
      logic [REG_W-1:0]  dest;
      logic [DATA_W-1:0] value;
   } rob_entry_t;
endpackage

// File: rtl/rob_entry_array.sv
// ROB entry storage: 1 alloc, 2 writeback,
// 2 operand read and 2 head read ports.
module rob_entry_array
   import rob_commit_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              alloc_we_i,
   input  logic [TAG_W-1:0]  alloc_idx_i,
   input  logic              alloc_has_dest_i,
   input  logic [REG_W-1:0]  alloc_dest_i,
   input  logic              wb0_valid_i,
   input  logic [TAG_W-1:0]  wb0_tag_i,
   input  logic [DATA_W-1:0] wb0_value_i,
   input  logic              wb1_valid_i,
   input  logic [TAG_W-1:0]  wb1_tag_i,
   input  logic [DATA_W-1:0] wb1_value_i,
   input  logic [TAG_W-1:0]  rd_tag_a_i,
   input  logic [TAG_W-1:0]  rd_tag_b_i,
   output logic              rd_ready_a_o,
   output logic [DATA_W-1:0] rd_value_a_o,
   output logic              rd_ready_b_o,
   output logic [DATA_W-1:0] rd_value_b_o,
   input  logic [TAG_W-1:0]  head0_idx_i,
   input  logic [TAG_W-1:0]  head1_idx_i,
   input  logic              clr0_i,
   input  logic              clr1_i,
   output rob_entry_t        head0_o,
   output rob_entry_t        head1_o
);

   rob_entry_t ent_q [DEPTH];

   logic a_m0, a_m1, b_m0, b_m1;

   // Entry update: wb1 lands after wb0, so it wins on equal tags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      end else if (flush_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i].valid <= 1'b0;
            ent_q[i].done  <= 1'b0;
         end
      end else begin
         if (wb0_valid_i && ent_q[wb0_tag_i].valid) begin
            ent_q[wb0_tag_i].done  <= 1'b1;
            ent_q[wb0_tag_i].value <= wb0_value_i;
         end
         if (wb1_valid_i && ent_q[wb1_tag_i].valid) begin
            ent_q[wb1_tag_i].done  <= 1'b1;
            ent_q[wb1_tag_i].value <= wb1_value_i;
         end
         if (alloc_we_i) begin
            ent_q[alloc_idx_i].valid    <= 1'b1;
            ent_q[alloc_idx_i].done     <= 1'b0;
            ent_q[alloc_idx_i].has_dest <= alloc_has_dest_i;
            ent_q[alloc_idx_i].dest     <= alloc_dest_i;
         end
         if (clr0_i) begin
            ent_q[head0_idx_i].valid <= 1'b0;
            ent_q[head0_idx_i].done  <= 1'b0;
         end
         if (clr1_i) begin
            ent_q[head1_idx_i].valid <= 1'b0;
            ent_q[head1_idx_i].done  <= 1'b0;
         end
      end
   end

   // Operand reads with same-cycle writeback bypass.
   always_comb begin
      a_m0 = wb0_valid_i && (wb0_tag_i == rd_tag_a_i);
      a_m1 = wb1_valid_i && (wb1_tag_i == rd_tag_a_i);
      b_m0 = wb0_valid_i && (wb0_tag_i == rd_tag_b_i);
      b_m1 = wb1_valid_i && (wb1_tag_i == rd_tag_b_i);
      rd_ready_a_o = ent_q[rd_tag_a_i].valid &&
                     (ent_q[rd_tag_a_i].done || a_m0 || a_m1);
      rd_ready_b_o = ent_q[rd_tag_b_i].valid &&
                     (ent_q[rd_tag_b_i].done || b_m0 || b_m1);
      rd_value_a_o = ent_q[rd_tag_a_i].value;
      if (a_m1)      rd_value_a_o = wb1_value_i;
      else if (a_m0) rd_value_a_o = wb0_value_i;
      rd_value_b_o = ent_q[rd_tag_b_i].value;
      if (b_m1)      rd_value_b_o = wb1_value_i;
      else if (b_m0) rd_value_b_o = wb0_value_i;
   end

   assign head0_o = ent_q[head0_idx_i];
   assign head1_o = ent_q[head1_idx_i];

endmodule

// File: rtl/rob_commit.sv
// Reorder buffer: tag allocation, writeback
// capture, operand reads, dual in-order retire.
module rob_commit
   import rob_commit_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              alloc_valid,
   input  logic              alloc_has_dest,
   input  logic [REG_W-1:0]  alloc_dest,
   output logic              alloc_ready,
   output logic [TAG_W-1:0]  alloc_tag,
   input  logic              wb0_valid,
   input  logic [TAG_W-1:0]  wb0_tag,
   input  logic [DATA_W-1:0] wb0_value,
   input  logic              wb1_valid,
   input  logic [TAG_W-1:0]  wb1_tag,
   input  logic [DATA_W-1:0] wb1_value,
   input  logic [TAG_W-1:0]  rd_tag_a,
   input  logic [TAG_W-1:0]  rd_tag_b,
   output logic              rd_ready_a,
   output logic              rd_ready_b,
   output logic [DATA_W-1:0] rd_value_a,
   output logic [DATA_W-1:0] rd_value_b,
   output logic              commit0_valid,
   output logic              commit1_valid,
   output logic              commit0_we,
   output logic              commit1_we,
   output logic [REG_W-1:0]  commit0_dest,
   output logic [REG_W-1:0]  commit1_dest,
   output logic [TAG_W-1:0]  commit0_tag,
   output logic [TAG_W-1:0]  commit1_tag,
   output logic [DATA_W-1:0] commit0_value,
   output logic [DATA_W-1:0] commit1_value,
   output logic              free0,
   output logic              free1,
   output logic [TAG_W:0]    count
);

   logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [TAG_W:0]   count_q, count_d;
   logic [TAG_W-1:0] head1_idx;
   logic             alloc_fire, c0, c1;
   rob_entry_t       h0, h1;

   assign head1_idx   = head_q + 1'b1;
   assign alloc_ready = !flush && (count_q < (TAG_W+1)'(DEPTH));
   assign alloc_fire  = alloc_valid && alloc_ready;
   assign alloc_tag   = tail_q;
   assign count       = count_q;

   assign c0 = !flush && h0.valid && h0.done;
   assign c1 = c0 && h1.valid && h1.done;

   assign commit0_valid = c0;
   assign commit1_valid = c1;
   assign commit0_we    = c0 && h0.has_dest;
   assign commit1_we    = c1 && h1.has_dest;
   assign free0         = commit0_we;
   assign free1         = commit1_we;
   assign commit0_dest  = h0.dest;
   assign commit1_dest  = h1.dest;
   assign commit0_tag   = head_q;
   assign commit1_tag   = head1_idx;
   assign commit0_value = h0.value;
   assign commit1_value = h1.value;

   rob_entry_array u_arr (
      .clk              (clk),
      .rst              (rst),
      .flush_i          (flush),
      .alloc_we_i       (alloc_fire),
      .alloc_idx_i      (tail_q),
      .alloc_has_dest_i (alloc_has_dest),
      .alloc_dest_i     (alloc_dest),
      .wb0_valid_i      (wb0_valid),
      .wb0_tag_i        (wb0_tag),
      .wb0_value_i      (wb0_value),
      .wb1_valid_i      (wb1_valid),
      .wb1_tag_i        (wb1_tag),
      .wb1_value_i      (wb1_value),
      .rd_tag_a_i       (rd_tag_a),
      .rd_tag_b_i       (rd_tag_b),
      .rd_ready_a_o     (rd_ready_a),
      .rd_value_a_o     (rd_value_a),
      .rd_ready_b_o     (rd_ready_b),
      .rd_value_b_o     (rd_value_b),
      .head0_idx_i      (head_q),
      .head1_idx_i      (head1_idx),
      .clr0_i           (c0),
      .clr1_i           (c1),
      .head0_o          (h0),
      .head1_o          (h1)
   );

   // Next pointers and occupancy; flush clears everything.
   always_comb begin
      head_d  = head_q + TAG_W'(c0) + TAG_W'(c1);
      tail_d  = tail_q + TAG_W'(alloc_fire);
      count_d = count_q + (TAG_W+1)'(alloc_fire)
                - (TAG_W+1)'(c0) - (TAG_W+1)'(c1);
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   // Pointer and count registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit with
// hand-computed expectations.
module tb_rob_commit;
   import rob_commit_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic              alloc_valid, alloc_has_dest;
   logic [REG_W-1:0]  alloc_dest;
   logic              alloc_ready;
   logic [TAG_W-1:0]  alloc_tag;
   logic              wb0_valid, wb1_valid;
   logic [TAG_W-1:0]  wb0_tag, wb1_tag;
   logic [DATA_W-1:0] wb0_value, wb1_value;
   logic [TAG_W-1:0]  rd_tag_a, rd_tag_b;
   logic              rd_ready_a, rd_ready_b;
   logic [DATA_W-1:0] rd_value_a, rd_value_b;
   logic              commit0_valid, commit1_valid;
   logic              commit0_we, commit1_we;
   logic [REG_W-1:0]  commit0_dest, commit1_dest;
   logic [TAG_W-1:0]  commit0_tag, commit1_tag;
   logic [DATA_W-1:0] commit0_value, commit1_value;
   logic              free0, free1;
   logic [TAG_W:0]    count;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   rob_commit dut (
      .clk(clk), .rst(rst), .flush(flush),
      .alloc_valid(alloc_valid),
      .alloc_has_dest(alloc_has_dest),
      .alloc_dest(alloc_dest),
      .alloc_ready(alloc_ready),
      .alloc_tag(alloc_tag),
      .wb0_valid(wb0_valid), .wb0_tag(wb0_tag),
      .wb0_value(wb0_value),
      .wb1_valid(wb1_valid), .wb1_tag(wb1_tag),
      .wb1_value(wb1_value),
      .rd_tag_a(rd_tag_a), .rd_tag_b(rd_tag_b),
      .rd_ready_a(rd_ready_a), .rd_ready_b(rd_ready_b),
      .rd_value_a(rd_value_a), .rd_value_b(rd_value_b),
      .commit0_valid(commit0_valid),
      .commit1_valid(commit1_valid),
      .commit0_we(commit0_we), .commit1_we(commit1_we),
      .commit0_dest(commit0_dest),
      .commit1_dest(commit1_dest),
      .commit0_tag(commit0_tag), .commit1_tag(commit1_tag),
      .commit0_value(commit0_value),
      .commit1_value(commit1_value),
      .free0(free0), .free1(free1),
      .count(count)
   );

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h",
                  tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush = 0; alloc_valid = 0;
      wb0_valid = 0; wb1_valid = 0;
   endtask

   task automatic alloc(input logic hd, input logic [4:0] d,
                        input logic [4:0] exp_tag);
      alloc_valid = 1; alloc_has_dest = hd; alloc_dest = d;
      #1;
      check("alloc_tag", alloc_tag, exp_tag);
      tick();
      alloc_valid = 0;
   endtask

   initial begin
      rst = 1; idle();
      alloc_has_dest = 0; alloc_dest = 0;
      wb0_tag = 0; wb1_tag = 0; wb0_value = 0; wb1_value = 0;
      rd_tag_a = 0; rd_tag_b = 0;
      #3;
      check("rst_ready", alloc_ready, 1);
      check("rst_tag", alloc_tag, 0);
      check("rst_count", count, 0);
      check("rst_c0", commit0_valid, 0);
      check("rst_free0", free0, 0);
      check("rst_rdy_a", rd_ready_a, 0);
      @(negedge clk); rst = 0;
      tick();

      alloc(1, 3, 0);
      alloc(1, 4, 1);
      alloc(1, 5, 2);
      check("cnt3", count, 3);
      check("no_c0", commit0_valid, 0);

      wb1_valid = 1; wb1_tag = 1; wb1_value = 32'hAA;
      #1;
      check("wb1_c0", commit0_valid, 0);
      tick(); idle();
      wb0_valid = 1; wb0_tag = 0; wb0_value = 32'h55;
      #1;
      check("samecyc_c0", commit0_valid, 0);
      tick(); idle();
      #1;
      check("c0_v", commit0_valid, 1);
      check("c0_dest", commit0_dest, 3);
      check("c0_val", commit0_value, 32'h55);
      check("c0_tag", commit0_tag, 0);
      check("c1_v", commit1_valid, 1);
      check("c1_dest", commit1_dest, 4);
      check("c1_val", commit1_value, 32'hAA);
      check("c1_tag", commit1_tag, 1);
      check("free0", free0, 1);
      check("free1", free1, 1);
      tick();
      check("cnt1", count, 1);

      rd_tag_a = 2;
      #1;
      check("rd_a_pre", rd_ready_a, 0);
      wb0_valid = 1; wb0_tag = 2; wb0_value = 32'h77;
      #1;
      check("rd_a_byp", rd_ready_a, 1);
      check("rd_a_val", rd_value_a, 32'h77);
      tick(); idle();
      #1;
      check("c0_e2", commit0_valid, 1);
      check("c0_e2val", commit0_value, 32'h77);
      check("c1_e2", commit1_valid, 0);
      tick();
      check("cnt0", count, 0);

      alloc(0, 7, 3);
      wb0_valid = 1; wb0_tag = 3; wb0_value = 32'h11;
      tick(); idle();
      #1;
      check("nd_c0", commit0_valid, 1);
      check("nd_we", commit0_we, 0);
      check("nd_free", free0, 0);
      tick();

      for (int i = 0; i < DEPTH; i++)
         alloc(1, 5'(i), 5'((i + 4) % DEPTH));
      check("full_cnt", count, 32);
      check("full_rdy", alloc_ready, 0);
      alloc_valid = 1; alloc_dest = 9;
      tick(); idle();
      check("full_ign", count, 32);
      check("full_tag", alloc_tag, 4);
      wb0_valid = 1; wb0_tag = 4; wb0_value = 32'h44;
      tick(); idle();
      alloc_valid = 1;
      #1;
      check("fc_c0", commit0_valid, 1);
      check("fc_tag", commit0_tag, 4);
      check("fc_dest", commit0_dest, 0);
      check("fc_rdy", alloc_ready, 0);
      tick(); idle();
      check("fc_cnt", count, 31);
      check("fc_rdy2", alloc_ready, 1);
      alloc(1, 1, 4);
      check("fc_cnt2", count, 32);

      flush = 1;
      #1;
      check("fl_rdy", alloc_ready, 0);
      tick(); idle();
      check("fl_cnt", count, 0);
      for (int i = 0; i < 5; i++) alloc(1, 5'(i + 10), 5'(i));
      wb0_valid = 1; wb0_tag = 0; wb0_value = 32'h1;
      wb1_valid = 1; wb1_tag = 1; wb1_value = 32'h2;
      tick(); idle();
      flush = 1; alloc_valid = 1;
      #1;
      check("fl_c0", commit0_valid, 0);
      check("fl_c1", commit1_valid, 0);
      check("fl_free0", free0, 0);
      check("fl_rdy2", alloc_ready, 0);
      tick(); idle();
      check("fl_cnt2", count, 0);
      check("fl_tag", alloc_tag, 0);
      check("fl_c0b", commit0_valid, 0);

      alloc(1, 6, 0);
      alloc(1, 7, 1);
      wb0_valid = 1; wb0_tag = 0; wb0_value = 32'h9;
      tick(); idle();
      check("pre_rst_c0", commit0_valid, 1);
      #2 rst = 1;
      #1;
      check("mr_cnt", count, 0);
      check("mr_tag", alloc_tag, 0);
      check("mr_rdy", alloc_ready, 1);
      check("mr_c0", commit0_valid, 0);
      check("mr_free0", free0, 0);
      @(negedge clk); rst = 0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- Reorder buffer that sits directly upstream of the register alias table in the out-of-order core.
- Hands out ROB tags at dispatch (these feed the alias table's tag input).
- Captures results from two writeback buses and serves operand values by tag.
- Retires up to two entries per cycle in program order. Each retirement drives a register-file write and a free request with tag to the alias table.

Parameters:
- DEPTH, 32, number of ROB entries; must equal 2**TAG_W.
- TAG_W, 5, tag width; matches the alias table tag width.
- DATA_W, 32, result width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  discard all in-flight entries (mispredict).
- alloc_valid  in  1  dispatch requests an entry.
- alloc_has_dest  in  1  instruction writes a register.
- alloc_dest  in  5  architectural destination register.
- alloc_ready  out  1  entry available this cycle.
- alloc_tag  out  TAG_W  tag granted (current tail).
- wb0_valid, wb1_valid  in  1  writeback bus valid.
- wb0_tag, wb1_tag  in  TAG_W  completing entry.
- wb0_value, wb1_value  in  DATA_W  result.
- rd_tag_a, rd_tag_b  in  TAG_W  operand lookup tags.
- rd_ready_a, rd_ready_b  out  1  entry result available.
- rd_value_a, rd_value_b  out  DATA_W  entry result.
- commit0_valid, commit1_valid  out  1  entry retiring this cycle.
- commit0_we, commit1_we  out  1  retiring entry writes the register file (has_dest).
- commit0_dest, commit1_dest  out  5  destination register.
- commit0_tag, commit1_tag  out  TAG_W  retiring tag; feeds alias table tag_done/tag_done2.
- commit0_value, commit1_value  out  DATA_W  retiring result.
- free0, free1  out  1  equal to commitN_valid & commitN_we; feeds alias table free/free2.
- count  out  TAG_W+1  occupied entries.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Per-entry state: valid, done, has_dest, dest[4:0], value[DATA_W-1:0]. Pointers: head and tail (TAG_W bits, wrap modulo DEPTH), count (TAG_W+1 bits).
- Reset (immediate, mid-operation included): head=tail=0, count=0, all valid/done=0. After reset: alloc_ready=1, alloc_tag=0, all commit/free outputs 0, rd_ready 0.
- Allocate:
  - alloc_ready = (count < DEPTH), computed from registered count only. There is no credit for same-cycle commits.
  - alloc_tag = tail, combinational.
  - On alloc_valid & alloc_ready: entry[tail] gets valid=1, done=0, has_dest, dest. tail increments.
  - alloc_valid while not ready is ignored with no state change.
- Writeback:
  - On wbN_valid with entry[wbN_tag].valid: set done=1 and store value.
  - Writeback to an invalid entry is ignored.
  - If wb0_tag == wb1_tag, wb1 wins.
  - A writeback on an already-done entry overwrites the value.
- Read:
  - rd_ready_x = entry valid & (done | matching wb valid this cycle).
  - rd_value_x bypasses the same-cycle wb value (wb1 over wb0), otherwise the stored value.
  - Purely combinational, zero latency.
- Commit (combinational outputs from registered state, zero latency):
  - commit0_valid = entry[head].valid & done.
  - commit1_valid = commit0_valid & entry[head+1].valid & done, with head+1 wrapping.
  - A same-cycle writeback does not enable commit; the entry retires on the next cycle at the earliest.
  - On the clock edge, retired entries are invalidated and head advances by the number of commits (0/1/2).
- Count update: count_next = count + alloc_fire - commits. Simultaneous alloc and commit at full is legal: alloc is refused, commits proceed.
- Wrap-around: tail/head roll from DEPTH-1 to 0. Full versus empty is distinguished by count only.
- Flush:
  - Outputs are gated that cycle: commit/free forced 0, alloc_ready forced 0.
  - At the edge: all valid=0, head=tail=0, count=0.
  - Flush has priority over alloc, writeback and commit in the same cycle.

Decomposition:
- Shared package: TAG_W, DATA_W, REG_W=5, DEPTH, and the entry struct (valid, done, has_dest, dest, value). The alias table uses the same TAG_W constant.
- One sub-module, rob_entry_array: entry storage with one allocate port, two writeback ports, two read ports and two head-read ports.
- Pointer, count and commit logic stays in rob_commit.

Test Plan:
- Reset, then alloc with dest 3, 4, 5 -> alloc_tag 0, 1, 2; count=3; no commits.
- wb1 tag1 value 0xAA, next cycle wb0 tag0 value 0x55 -> no commit until the cycle after tag0's writeback. Then commit0 (dest3, 0x55) and commit1 (dest4, 0xAA) with free0=free1=1; count 3->1.
- Fill all 32 entries -> alloc_ready=0 and a 33rd alloc is ignored. Complete head and commit -> alloc_ready=1 next cycle; tail wraps 31->0 and the new alloc_tag=0.
- alloc_has_dest=0 entry completes -> commit0_valid=1, commit0_we=0, free0=0.
- rd_tag_a=2 with wb0 tag2 value 0x77 in the same cycle -> rd_ready_a=1, rd_value_a=0x77 combinationally.
- Flush with 5 entries, two of them done -> no commit that cycle; next cycle count=0, alloc_tag=0. Assert rst mid-traffic -> all outputs at reset values immediately, without waiting for a clock.
